// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Optional MIXCOL_BYPASS_EN adds in_bypass so a block can pass through unmixed.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic         in_bypass,
`endif
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int N = (COLS_PER_CYCLE > 0) ? (4 / COLS_PER_CYCLE) : 1;
    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   data_q, data_d;
    logic [2:0]     idx_q, idx_d;
    logic           inv_q, inv_d;
    logic           byp_q, byp_d;
    logic           byp_in;

    logic [127:0]   src;
    logic [127:0]   mixed;
    logic [2:0]     base;
    logic           sel_inv;
    logic           sel_byp;

`ifdef MIXCOL_BYPASS_EN
    assign byp_in = in_bypass;
`else
    assign byp_in = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply by a 4-bit coefficient: sum of b, x2, x4, x8 terms.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        if (inv) begin
            r0 = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            r1 = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            r2 = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            r3 = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end else begin
            r0 = gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3;
            r1 = a0 ^ gmul(a1, 4'h2) ^ gmul(a2, 4'h3) ^ a3;
            r2 = a0 ^ a1 ^ gmul(a2, 4'h2) ^ gmul(a3, 4'h3);
            r3 = gmul(a0, 4'h3) ^ a1 ^ a2 ^ gmul(a3, 4'h2);
        end
        return {r0, r1, r2, r3};
    endfunction

    // In IDLE the first column group is mixed straight from data_in as the block is accepted.
    always_comb begin
        src     = data_q;
        base    = idx_q;
        sel_inv = inv_q;
        sel_byp = byp_q;
        if (state_q == IDLE) begin
            src     = data_in;
            base    = 3'd0;
            sel_inv = in_inv;
            sel_byp = byp_in;
        end
        mixed = src;
        for (int c = 0; c < 4; c++) begin
            if (!sel_byp && c >= int'(base) && c < int'(base) + COLS_PER_CYCLE) begin
                mixed[127-32*c -: 32] = mix_col(src[127-32*c -: 32], sel_inv);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        byp_d   = byp_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = mixed;
                    inv_d  = in_inv;
                    byp_d  = byp_in;
                    if (N == 1) begin
                        state_d = DONE;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = BUSY;
                        idx_d   = STEP;
                    end
                end
            end
            BUSY: begin
                data_d = mixed;
                if (idx_q + STEP == 3'd4) begin
                    state_d = DONE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + STEP;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            inv_q   <= inv_d;
            byp_q   <= byp_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (4, 2, 1 columns per cycle) driven one at a time,
// expected blocks queued at send time and popped when out_valid appears.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid_a [3];
    logic         in_ready_a [3];
    logic         in_inv_a   [3];
    logic [127:0] data_in_a  [3];
    logic         out_valid_a[3];
    logic         out_ready_a[3];
    logic [127:0] data_out_a [3];
`ifdef MIXCOL_BYPASS_EN
    logic         in_bypass_a[3];
`endif

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(
            .COLS_PER_CYCLE((g == 0) ? 4 : ((g == 1) ? 2 : 1))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready_a[g]),
            .in_inv   (in_inv_a[g]),
`ifdef MIXCOL_BYPASS_EN
            .in_bypass(in_bypass_a[g]),
`endif
            .data_in  (data_in_a[g]),
            .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a[g]),
            .data_out (data_out_a[g])
        );
    end

    // Reference GF(2^8) multiply: carry-less product then reduction by 0x11B.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [7:0]   v[4];
        logic [127:0] o;
        logic [7:0]   acc;
        if (inv) begin v[0] = 8'h0e; v[1] = 8'h0b; v[2] = 8'h0d; v[3] = 8'h09; end
        else     begin v[0] = 8'h02; v[1] = 8'h03; v[2] = 8'h01; v[3] = 8'h01; end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gm(v[(k - r + 4) % 4], d[127 - 32*c - 8*k -: 8]);
                o[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [127:0] din, input logic inv,
                        input bit push, input logic [127:0] exp);
        int k = 0;
        while (in_ready_a[d] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", 128'(in_ready_a[d]), 128'(1));
        in_valid_a[d] = 1'b1;
        data_in_a[d]  = din;
        in_inv_a[d]   = inv;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid_a[d] = 1'b0;
    endtask

    task automatic recv(input int d, input bit tog);
        int k = 1;
        logic [127:0] e;
        while (out_valid_a[d] !== 1'b1 && k < 40) begin
            if (tog) in_inv_a[d] = ~in_inv_a[d];
            @(negedge clk);
            k++;
        end
        chk("latency", 128'(k), 128'(lat(d)));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk("data_out", data_out_a[d], e);
        out_ready_a[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_a[d] = 1'b0;
        chk("back_idle", 128'({in_ready_a[d], out_valid_a[d]}), 128'(2'b10));
    endtask

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    initial begin
        logic [127:0] r;
        logic         ri;
        int           stale;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_inv_a[i]    = 1'b0;
            data_in_a[i]   = '0;
            out_ready_a[i] = 1'b0;
`ifdef MIXCOL_BYPASS_EN
            in_bypass_a[i] = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 128'(in_ready_a[i]), 128'(1));
            chk("rst_out_valid", 128'(out_valid_a[i]), 128'(0));
            chk("rst_data_out", data_out_a[i], 128'h0);
        end

        // Forward and inverse on 4-column engine, inverse and forward on 1-column engine
        send(0, V1_IN, 1'b0, 1'b1, V1_OUT);
        recv(0, 1'b0);
        send(0, V1_OUT, 1'b1, 1'b1, V1_IN);
        recv(0, 1'b0);
        send(2, V1_OUT, 1'b1, 1'b1, V1_IN);
        recv(2, 1'b0);
        send(2, V1_IN, 1'b0, 1'b1, V1_OUT);
        recv(2, 1'b0);

        // Backpressure with a second block waiting on in_valid
        send(0, V1_IN, 1'b0, 1'b1, V1_OUT);
        chk("bp_valid", 128'(out_valid_a[0]), 128'(1));
        r = exp_q.pop_front();
        in_valid_a[0] = 1'b1;
        data_in_a[0]  = 128'h01234567_89abcdef_fedcba98_76543210;
        in_inv_a[0]   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", data_out_a[0], r);
            chk("bp_ready", 128'({in_ready_a[0], out_valid_a[0]}), 128'(2'b01));
            @(negedge clk);
        end
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        chk("bp_release", 128'({in_ready_a[0], out_valid_a[0]}), 128'(2'b10));
        exp_q.push_back(model(data_in_a[0], 1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        recv(0, 1'b0);

        // Mode sampled only at acceptance, 2-column engine
        send(1, {4{32'hd4d4d4d5}}, 1'b0, 1'b1, {4{32'hd5d5d7d6}});
        recv(1, 1'b1);
        in_inv_a[1] = 1'b0;

        // Reset in BUSY discards the block
        send(2, V1_IN, 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 128'(out_valid_a[2]), 128'(0));
        chk("midrst_data_out", data_out_a[2], 128'h0);
        chk("midrst_in_ready", 128'(in_ready_a[2]), 128'(1));
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_a[2] === 1'b1) stale++;
        end
        chk("midrst_no_stale", 128'(stale), 128'(0));

        // Random blocks, both modes, all engine widths
        for (int i = 0; i < 6; i++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            ri = 1'($urandom_range(0, 1));
            send(i % 3, r, ri, 1'b1, model(r, ri));
            recv(i % 3, 1'b0);
        end

`ifdef MIXCOL_BYPASS_EN
        in_bypass_a[0] = 1'b1;
        send(0, 128'h2d26314c_00000000_ffffffff_12345678, 1'b0, 1'b1,
             128'h2d26314c_00000000_ffffffff_12345678);
        recv(0, 1'b0);
        in_bypass_a[0] = 1'b0;
        in_bypass_a[2] = 1'b1;
        send(2, 128'h2d26314c_00000000_ffffffff_12345678, 1'b1, 1'b1,
             128'h2d26314c_00000000_ffffffff_12345678);
        recv(2, 1'b0);
        in_bypass_a[2] = 1'b0;
        send(2, V1_IN, 1'b0, 1'b1, V1_OUT);
        recv(2, 1'b0);
`endif

        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
